// File: rtl/sprite_eval_ctrl_if.sv
// Sprite evaluation bus bundle.
// Purpose: groups the control, primary-OAM read and secondary-OAM write signals
// of sprite_eval_ctrl so the engine and its neighbours connect through one port.
// Signals:
//   Start, Scanline, Size16  - evaluation request and parameters (to engine)
//   OAM_Data                 - primary-OAM read data (to engine)
//   OAM_Addr                 - primary-OAM byte address (from engine)
//   SOAM_Addr/Data/WE        - secondary-OAM write port (from engine)
//   Busy, Done               - evaluation status (from engine)
//   Sprite_Count, Overflow, Sprite0_In - evaluation results (from engine)
interface sprite_eval_ctrl_if;
   logic       Start;
   logic [7:0] Scanline;
   logic       Size16;
   logic [7:0] OAM_Data;
   logic [7:0] OAM_Addr;
   logic [4:0] SOAM_Addr;
   logic [7:0] SOAM_Data;
   logic       SOAM_WE;
   logic       Busy;
   logic       Done;
   logic [3:0] Sprite_Count;
   logic       Overflow;
   logic       Sprite0_In;

   // Engine side
   modport slave (
      input  Start, Scanline, Size16, OAM_Data,
      output OAM_Addr, SOAM_Addr, SOAM_Data, SOAM_WE, Busy, Done,
             Sprite_Count, Overflow, Sprite0_In
   );

   // Controller / memory side
   modport master (
      output Start, Scanline, Size16, OAM_Data,
      input  OAM_Addr, SOAM_Addr, SOAM_Data, SOAM_WE, Busy, Done,
             Sprite_Count, Overflow, Sprite0_In
   );
endinterface

// File: rtl/sprite_eval_ctrl.sv
// Per-scanline sprite evaluation engine.
// Purpose: on Start, clears the 32-byte secondary OAM, scans the 64 primary-OAM
// entries in order against the target scanline and copies the first 8 in-range
// sprites (4 bytes each) into secondary-OAM slots 0..7.
// Ports:
//   Clk      - system clock, rising edge
//   Reset_n  - asynchronous active-low reset
//   bus      - sprite_eval_ctrl_if.slave: request inputs, primary-OAM read,
//              secondary-OAM write port, status and result outputs
// Parameters:
//   CLEAR_VAL - byte written to every secondary-OAM location during clear
module sprite_eval_ctrl #(
   parameter logic [7:0] CLEAR_VAL = 8'hFF
) (
   input logic             Clk,
   input logic             Reset_n,
   sprite_eval_ctrl_if.slave bus
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_SCAN  = 3'd2;
   localparam logic [2:0] ST_COPY  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic [2:0] r_state;
   logic [4:0] r_clr;    // clear address
   logic [5:0] r_n;      // primary-OAM sprite index
   logic [1:0] r_k;      // byte within sprite during copy
   logic [3:0] r_count;
   logic       r_ovf;
   logic       r_spr0;

   logic [8:0] w_diff;
   logic       w_in_range;
   logic       w_slots_full;

   // A borrow out of bit 8 means Y lies below the scanline: never in range.
   assign w_diff       = {1'b0, bus.Scanline} - {1'b0, bus.OAM_Data};
   assign w_in_range   = !w_diff[8] && (w_diff[7:0] < (bus.Size16 ? 8'd16 : 8'd8));
   assign w_slots_full = r_count[3];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= ST_IDLE;
         r_clr   <= '0;
         r_n     <= '0;
         r_k     <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_spr0  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_clr <= '0;
               r_n   <= '0;
               r_k   <= '0;
               // Results are held here until a new run is actually accepted.
               if (bus.Start) begin
                  r_state <= ST_CLEAR;
                  r_count <= '0;
                  r_ovf   <= 1'b0;
                  r_spr0  <= 1'b0;
               end
            end
            ST_CLEAR: begin
               r_clr <= r_clr + 5'd1;
               if (r_clr == 5'd31) begin
                  r_state <= ST_SCAN;
                  r_n     <= '0;
               end
            end
            ST_SCAN: begin
               if (w_in_range) begin
                  if (!w_slots_full) begin
                     r_k     <= 2'd1;
                     r_state <= ST_COPY;
                     if (r_n == 6'd0) begin
                        r_spr0 <= 1'b1;
                     end
                  end else begin
                     r_ovf   <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end else if (r_n == 6'd63) begin
                  r_state <= ST_DONE;
               end else begin
                  r_n <= r_n + 6'd1;
               end
            end
            ST_COPY: begin
               r_k <= r_k + 2'd1;
               if (r_k == 2'd3) begin
                  r_count <= r_count + 4'd1;
                  if (r_n == 6'd63) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_n     <= r_n + 6'd1;
                     r_state <= ST_SCAN;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Address/data are driven to zero whenever no access is in progress.
   always_comb begin
      bus.OAM_Addr  = 8'd0;
      bus.SOAM_Addr = 5'd0;
      bus.SOAM_Data = 8'd0;
      bus.SOAM_WE   = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            bus.SOAM_WE   = 1'b1;
            bus.SOAM_Addr = r_clr;
            bus.SOAM_Data = CLEAR_VAL;
         end
         ST_SCAN: begin
            bus.OAM_Addr = {r_n, 2'b00};
            if (w_in_range && !w_slots_full) begin
               bus.SOAM_WE   = 1'b1;
               bus.SOAM_Addr = {r_count[2:0], 2'b00};
               bus.SOAM_Data = bus.OAM_Data;
            end
         end
         ST_COPY: begin
            bus.OAM_Addr  = {r_n, r_k};
            bus.SOAM_WE   = 1'b1;
            bus.SOAM_Addr = {r_count[2:0], r_k};
            bus.SOAM_Data = bus.OAM_Data;
         end
         default: begin
         end
      endcase
   end

   assign bus.Busy         = (r_state == ST_CLEAR) || (r_state == ST_SCAN) ||
                             (r_state == ST_COPY);
   assign bus.Done         = (r_state == ST_DONE);
   assign bus.Sprite_Count = r_count;
   assign bus.Overflow     = r_ovf;
   assign bus.Sprite0_In   = r_spr0;

endmodule

// File: tb/tb_sprite_eval_ctrl.sv
// Self-checking bench for sprite_eval_ctrl: table of evaluation scenarios with a
// scoreboard of expected secondary-OAM writes, plus reset and Start-held sequences.
module tb_sprite_eval_ctrl;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   always #5 Clk = ~Clk;

   sprite_eval_ctrl_if bus ();

   sprite_eval_ctrl #(.CLEAR_VAL(8'hFF)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   logic [7:0] oam [256];
   assign bus.OAM_Data = oam[bus.OAM_Addr];

   typedef struct {
      logic [4:0] a;
      logic [7:0] d;
   } wr_t;
   wr_t exp_q[$];

   typedef struct {
      int         pat;
      logic [7:0] sl;
      logic       s16;
      int         cnt;
      int         ovf;
      int         s0;
      int         done_cyc;
   } vec_t;
   vec_t vecs[7];

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_oam_addr"},  32'(bus.OAM_Addr), 0);
      chk({tag, "_soam_addr"}, 32'(bus.SOAM_Addr), 0);
      chk({tag, "_soam_data"}, 32'(bus.SOAM_Data), 0);
      chk({tag, "_soam_we"},   32'(bus.SOAM_WE), 0);
      chk({tag, "_busy"},      32'(bus.Busy), 0);
      chk({tag, "_done"},      32'(bus.Done), 0);
      chk({tag, "_count"},     32'(bus.Sprite_Count), 0);
      chk({tag, "_ovf"},       32'(bus.Overflow), 0);
      chk({tag, "_spr0"},      32'(bus.Sprite0_In), 0);
   endtask

   // Y bytes default to 0xF0 (off-screen); other bytes are distinct filler.
   task automatic load_pat(input int p);
      for (int i = 0; i < 256; i++) begin
         oam[i] = ((i % 4) == 0) ? 8'hF0 : 8'(i ^ 'h5A);
      end
      case (p)
         1: begin
            oam[0] = 8'd20; oam[5*4] = 8'd20; oam[63*4] = 8'd20;
         end
         2: for (int s = 0; s < 10; s++) oam[s*4] = 8'd50;
         3: begin
            for (int s = 0; s < 7; s++) oam[s*4] = 8'd100;
            oam[63*4] = 8'd100;
         end
         4: begin
            oam[1*4] = 8'd93;   // Scanline-7: in
            oam[2*4] = 8'd92;   // Scanline-8: out
            oam[3*4] = 8'd101;  // above scanline: out
            oam[4*4] = 8'd100;  // equal: in
            oam[5*4] = 8'hFE;   // no wrap-around: out
         end
         default: begin
         end
      endcase
   endtask

   // Reference model: expected secondary-OAM write stream for one run.
   task automatic build_exp(input logic [7:0] sl, input logic s16);
      int cnt;
      int d;
      int h;
      wr_t w;
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
         w.a = 5'(i);
         w.d = 8'hFF;
         exp_q.push_back(w);
      end
      cnt = 0;
      h = s16 ? 16 : 8;
      for (int n = 0; n < 64; n++) begin
         d = int'(sl) - int'(oam[n*4]);
         if (d >= 0 && d < h) begin
            if (cnt == 8) break;
            for (int b = 0; b < 4; b++) begin
               w.a = 5'(cnt * 4 + b);
               w.d = oam[n*4 + b];
               exp_q.push_back(w);
            end
            cnt++;
         end
      end
   endtask

   task automatic run_vec(input int i);
      wr_t e;
      int  done_at;
      bit  got_done;
      load_pat(vecs[i].pat);
      bus.Scanline = vecs[i].sl;
      bus.Size16   = vecs[i].s16;
      build_exp(vecs[i].sl, vecs[i].s16);
      @(negedge Clk);
      bus.Start = 1'b1;
      @(posedge Clk);
      got_done = 0;
      done_at  = 0;
      for (int cyc = 1; cyc <= 400 && !got_done; cyc++) begin
         @(negedge Clk);
         if (cyc == 1) begin
            bus.Start = 1'b0;
            chk($sformatf("v%0d_busy_c1", i), 32'(bus.Busy), 1);
         end
         if (bus.SOAM_WE) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL v%0d_extra_write: got addr=%0h data=%0h expected no write",
                        i, bus.SOAM_Addr, bus.SOAM_Data);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("v%0d_soam_addr", i), 32'(bus.SOAM_Addr), 32'(e.a));
               chk($sformatf("v%0d_soam_data", i), 32'(bus.SOAM_Data), 32'(e.d));
            end
         end
         if (bus.Done) begin
            got_done = 1;
            done_at  = cyc;
         end
      end
      chk($sformatf("v%0d_done_cycle", i), 32'(done_at), 32'(vecs[i].done_cyc));
      chk($sformatf("v%0d_busy_at_done", i), 32'(bus.Busy), 0);
      chk($sformatf("v%0d_count", i), 32'(bus.Sprite_Count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_ovf", i), 32'(bus.Overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_spr0", i), 32'(bus.Sprite0_In), 32'(vecs[i].s0));
      chk($sformatf("v%0d_missing_writes", i), 32'(exp_q.size()), 0);
      @(negedge Clk);
      chk($sformatf("v%0d_done_pulse", i), 32'(bus.Done), 0);
      chk($sformatf("v%0d_hold_count", i), 32'(bus.Sprite_Count), 32'(vecs[i].cnt));
   endtask

   initial begin
      int  ndone;
      int  d1;
      int  d2;
      bit  found;

      //        pat  sl      s16  cnt ovf s0 done
      vecs[0] = '{0, 8'd10,  1'b0, 0, 0, 0, 97};
      vecs[1] = '{1, 8'd27,  1'b0, 3, 0, 1, 106};
      vecs[2] = '{1, 8'd28,  1'b0, 0, 0, 0, 97};
      vecs[3] = '{1, 8'd28,  1'b1, 3, 0, 1, 106};
      vecs[4] = '{2, 8'd50,  1'b0, 8, 1, 1, 66};
      vecs[5] = '{3, 8'd100, 1'b0, 8, 0, 1, 121};
      vecs[6] = '{4, 8'd100, 1'b0, 2, 0, 0, 103};

      bus.Start    = 1'b0;
      bus.Scanline = 8'd0;
      bus.Size16   = 1'b0;
      load_pat(0);
      #1;
      chk_zero_outputs("por");
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_vec(i);
      end

      // Reset asserted while copying sprite 0, then a clean rerun.
      load_pat(1);
      bus.Scanline = 8'd27;
      bus.Size16   = 1'b0;
      @(negedge Clk);
      bus.Start = 1'b1;
      @(posedge Clk);
      found = 0;
      for (int cyc = 1; cyc <= 200 && !found; cyc++) begin
         @(negedge Clk);
         bus.Start = 1'b0;
         if (bus.SOAM_WE && bus.SOAM_Addr == 5'd2 && bus.OAM_Addr == 8'd2) found = 1;
      end
      chk("rst_reached_copy", 32'(found), 1);
      Reset_n = 1'b0;
      #1;
      chk_zero_outputs("midrst");
      @(negedge Clk);
      Reset_n = 1'b1;
      run_vec(1);

      // Start held high through DONE: second run accepted in the IDLE cycle after Done.
      load_pat(0);
      bus.Scanline = 8'd10;
      bus.Size16   = 1'b0;
      @(negedge Clk);
      bus.Start = 1'b1;
      @(posedge Clk);
      ndone = 0;
      d1 = 0;
      d2 = 0;
      for (int cyc = 1; cyc <= 260; cyc++) begin
         @(negedge Clk);
         if (cyc == 98) chk("hold_idle_busy", 32'(bus.Busy), 0);
         if (cyc == 99) begin
            chk("hold_rerun_busy", 32'(bus.Busy), 1);
            chk("hold_rerun_we", 32'(bus.SOAM_WE), 1);
            chk("hold_rerun_addr", 32'(bus.SOAM_Addr), 0);
         end
         if (cyc == 120) bus.Start = 1'b0;
         if (bus.Done) begin
            ndone++;
            if (ndone == 1) d1 = cyc;
            if (ndone == 2) d2 = cyc;
         end
      end
      chk("hold_done_count", 32'(ndone), 2);
      chk("hold_done1", 32'(d1), 97);
      chk("hold_done2", 32'(d2), 195);
      chk("hold_final_busy", 32'(bus.Busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_eval_ctrl.md
# sprite_eval_ctrl

- Per-scanline sprite evaluation engine.
- On each Start it does three things:
  - clears the 32-byte secondary OAM to CLEAR_VAL;
  - scans all 64 primary-OAM entries in index order against the target scanline;
  - copies the first 8 in-range sprites (4 bytes each) into secondary OAM slots 0..7.
- Sits directly upstream of the secondary-OAM pointer/fetch stage: that stage only indexes secondary OAM after Done.

## Interface
Parameters:
- CLEAR_VAL, 8'hFF, byte written to every secondary-OAM location during clear

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  begin evaluation; accepted only in IDLE
- Scanline  in  8  target scanline; must be held stable while Busy
- Size16  in  1  1 = 8x16 sprites (height 16), 0 = 8x8 (height 8); held stable while Busy
- OAM_Data  in  8  primary-OAM read data; asynchronous read, valid same cycle as OAM_Addr
- OAM_Addr  out  8  primary-OAM byte address, = {sprite index[5:0], byte[1:0]}
- SOAM_Addr  out  5  secondary-OAM byte address, = {slot[2:0], byte[1:0]}
- SOAM_Data  out  8  secondary-OAM write data
- SOAM_WE  out  1  secondary-OAM write enable, one byte per cycle
- Busy  out  1  high in CLEAR, SCAN, COPY
- Done  out  1  one-cycle pulse at end of evaluation
- Sprite_Count  out  4  sprites copied, 0..8
- Overflow  out  1  a 9th in-range sprite exists on this scanline
- Sprite0_In  out  1  sprite 0 was copied into slot 0

## Operation
- States: IDLE, CLEAR, SCAN, COPY, DONE.
- IDLE:
  - Start=1 → CLEAR.
  - Clear Sprite_Count, Overflow, Sprite0_In; zero clear counter and sprite index n.
- CLEAR: 32 cycles.
  - Cycle i: SOAM_WE=1, SOAM_Addr=i, SOAM_Data=CLEAR_VAL.
  - After i=31 → SCAN with n=0.
- SCAN: one cycle per sprite.
  - OAM_Addr={n,2'b00}; Y=OAM_Data.
  - d = {1'b0,Scanline} − {1'b0,Y} (9-bit).
  - In range iff d[8]=0 and d[7:0] < (Size16 ? 16 : 8).
  - In range and Sprite_Count<8:
    - SOAM_WE=1, SOAM_Addr={Sprite_Count[2:0],2'b00}, SOAM_Data=Y.
    - If n=0, set Sprite0_In.
    - → COPY with byte k=1.
  - In range and Sprite_Count=8: set Overflow → DONE. This is a correct overflow rule; there is no diagonal-scan quirk.
  - Not in range: n=63 → DONE, else n+1 → SCAN.
- COPY: 3 cycles, k=1..3.
  - OAM_Addr={n,k}.
  - SOAM_WE=1, SOAM_Addr={Sprite_Count[2:0],k}, SOAM_Data=OAM_Data.
  - On k=3: Sprite_Count+1; then n=63 → DONE, else n+1 → SCAN.
- DONE: Done=1 for one cycle → IDLE.
- Sprite_Count, Overflow, Sprite0_In hold their values through IDLE until the next accepted Start.
- Start in any state other than IDLE (including DONE) is ignored.
- Secondary OAM is only written with SOAM_WE=1. No other output strobes.

## Timing
- Reset (Reset_n=0, immediate, mid-operation included):
  - State returns to IDLE.
  - All outputs 0 (OAM_Addr=0, SOAM_Addr=0, SOAM_Data=0, SOAM_WE=0, Busy=0, Done=0, Sprite_Count=0, Overflow=0, Sprite0_In=0).
  - Partially written secondary OAM is not repaired; the next Start clears it.
- Start sampled high at edge E0 → Busy=1 and first clear write from cycle 1.
- Busy duration N:
  - No overflow, k sprites copied: N = 32 + 64 + 3k.
  - Overflow detected at sprite index m: N = 32 + (m+1) + 24.
- Busy is high cycles 1..N; Done is high in cycle N+1 only.
- Back-to-back: Start may be high in the cycle after Done (IDLE) and is accepted there.
- Boundary rules:
  - Y=Scanline is in range.
  - Y=Scanline−7 is in range at height 8 and out at Scanline−8.
  - Y>Scanline is never in range; there is no wrap-around.
  - Sprite 63 in range with 7 already copied: copied, Sprite_Count=8, Overflow=0.

## Test plan
- Reset mid-COPY (Reset_n low 1 cycle):
  - All outputs 0 immediately.
  - Then Start gives a full clean run.
- All 64 sprites Y=0xF0, Scanline=10, Size16=0:
  - 32 writes of 0xFF.
  - Done at cycle 97; Sprite_Count=0, Overflow=0, Sprite0_In=0.
- Sprites 0, 5, 63 with Y=20, others Y=0xF0, Scanline=27, height 8:
  - Slots 0..2 hold their 4 bytes; Sprite0_In=1; Count=3.
  - Done at cycle 32+64+9+1=106.
- Same sprites, Scanline=28, Size16=0 → none copied. Size16=1 → all 3 copied.
- Sprites 0..9 all Y=50, Scanline=50:
  - Slots filled with sprites 0..7; Overflow=1 detected at m=8.
  - Done at cycle 32+9+24+1=66; slots untouched after overflow.
- Start held high through DONE: exactly one run per IDLE acceptance, and a second run starts the cycle after Done.
